// File: rtl/deckeygen_seq.sv
// DES decryption key scheduler: PC-1 once, then right-rotate C/D between keys and apply PC-2.
// Emits K16..K1 one per valid/ready handshake, with no bubble when key_ready stays high.
module deckeygen_seq #(
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_i,
  input  logic        start,
  output logic        busy,
  output logic [47:0] round_key_o,
  output logic [3:0]  round_idx_o,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        done
);

  typedef enum logic {StIdle, StEmit} state_e;

  // Entries are FIPS 46-3 bit numbers, 1 = MSB of the source vector.
  localparam int unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] f_pc1(input logic [63:0] k);
    logic [55:0] v;
    v = '0;
    for (int j = 0; j < 56; j++) begin
      v[55-j] = k[64-PC1_TBL[j]];
    end
    return v;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] cd);
    logic [47:0] v;
    v = '0;
    for (int j = 0; j < 48; j++) begin
      v[47-j] = cd[56-PC2_TBL[j]];
    end
    return v;
  endfunction

  function automatic logic [27:0] f_ror(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_e      r_state, w_state;
  logic [27:0] r_c, w_c;
  logic [27:0] r_d, w_d;
  logic [47:0] r_key, w_key;
  logic [3:0]  r_idx, w_idx;
  logic        r_busy, w_busy;
  logic        r_valid, w_valid;
  logic        r_done, w_done;

  logic [55:0] w_pc1;
  logic [3:0]  w_idx_inc;
  logic        w_two;
  logic [27:0] w_c_rot;
  logic [27:0] w_d_rot;

  assign w_pc1     = f_pc1(key_i);
  assign w_idx_inc = r_idx + 4'd1;
  // Single-step rotations land on decryption indices 1, 8 and 15.
  assign w_two     = !((w_idx_inc == 4'd1) || (w_idx_inc == 4'd8) || (w_idx_inc == 4'd15));
  assign w_c_rot   = f_ror(r_c, w_two);
  assign w_d_rot   = f_ror(r_d, w_two);

  always_comb begin
    w_state = r_state;
    w_c     = r_c;
    w_d     = r_d;
    w_key   = r_key;
    w_idx   = r_idx;
    w_busy  = r_busy;
    w_valid = r_valid;
    w_done  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_c     = w_pc1[55:28];
          w_d     = w_pc1[27:0];
          w_key   = f_pc2(w_pc1);
          w_idx   = 4'd0;
          w_busy  = 1'b1;
          w_valid = 1'b1;
          w_state = StEmit;
        end
      end
      StEmit: begin
        if (key_ready) begin
          if (r_idx == 4'd15) begin
            w_valid = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = StIdle;
            if (CLEAR_ON_DONE) begin
              w_c   = '0;
              w_d   = '0;
              w_key = '0;
              w_idx = 4'd0;
            end
          end else begin
            w_c   = w_c_rot;
            w_d   = w_d_rot;
            w_key = f_pc2({w_c_rot, w_d_rot});
            w_idx = w_idx_inc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_c     <= '0;
      r_d     <= '0;
      r_key   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_c     <= w_c;
      r_d     <= w_d;
      r_key   <= w_key;
      r_idx   <= w_idx;
      r_busy  <= w_busy;
      r_valid <= w_valid;
      r_done  <= w_done;
    end
  end

  assign busy        = r_busy;
  assign key_valid   = r_valid;
  assign done        = r_done;
  assign round_key_o = r_key;
  assign round_idx_o = r_idx;

endmodule
